// File: rtl/sram_1rw_req_resp_adapter_if.sv
// Request/response channel bundle between a memory initiator and the
// single-port SRAM adapter.
//   master: drives req_val/req_type/req_addr/req_data/req_strb and resp_rdy
//   slave : drives req_rdy and resp_val/resp_type/resp_data
interface sram_1rw_req_resp_adapter_if #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 256
);
    localparam int c_addr_nbits  = $clog2(p_num_entries);
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8;

    logic                     req_val;
    logic                     req_rdy;
    logic                     req_type;
    logic [c_addr_nbits-1:0]  req_addr;
    logic [p_data_nbits-1:0]  req_data;
    logic [c_data_nbytes-1:0] req_strb;

    logic                     resp_val;
    logic                     resp_rdy;
    logic                     resp_type;
    logic [p_data_nbits-1:0]  resp_data;

    modport master (
        output req_val, req_type, req_addr, req_data, req_strb, resp_rdy,
        input  req_rdy, resp_val, resp_type, resp_data
    );

    modport slave (
        input  req_val, req_type, req_addr, req_data, req_strb, resp_rdy,
        output req_rdy, resp_val, resp_type, resp_data
    );
endinterface

// File: rtl/sram_1rw_req_resp_adapter.sv
// Initiator-side controller for a single-port synchronous SRAM.
// Accepts val/rdy read / byte-masked write requests, issues them to the SRAM
// in the same cycle, absorbs the one-cycle read latency and returns in-order
// val/rdy responses through a 2-entry buffer.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   bus (slave)         request/response channels
//   sram_read_*         SRAM read port (data valid one cycle after read_en)
//   sram_write_*        SRAM write port with byte enables
module sram_1rw_req_resp_adapter #(
    parameter int  p_data_nbits  = 32,
    parameter int  p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_1rw_req_resp_adapter_if.slave bus,
    output logic                      sram_read_en,
    output logic [c_addr_nbits-1:0]   sram_read_addr,
    input  logic [p_data_nbits-1:0]   sram_read_data,
    output logic                      sram_write_en,
    output logic [c_data_nbytes-1:0]  sram_write_byte_en,
    output logic [c_addr_nbits-1:0]   sram_write_addr,
    output logic [p_data_nbits-1:0]   sram_write_data
);

    logic                          fire;
    logic                          req_rdy_i;
    logic                          p_val;
    logic                          p_type;

    logic [1:0]                    buf_type;
    logic [1:0][p_data_nbits-1:0]  buf_data;
    logic [1:0]                    count;
    logic                          rd_ptr;
    logic                          wr_ptr;
    logic                          push;
    logic                          deq;
    logic                          resp_val_i;
    logic [2:0]                    occ;
    logic [p_data_nbits-1:0]       push_data;

    // Issue stage: requests go straight to the SRAM in the accept cycle.
    assign fire               = bus.req_val & req_rdy_i;
    assign sram_read_en       = fire & ~bus.req_type;
    assign sram_write_en      = fire & bus.req_type;
    assign sram_read_addr     = bus.req_addr;
    assign sram_write_addr    = bus.req_addr;
    assign sram_write_data    = bus.req_data;
    assign sram_write_byte_en = bus.req_strb;

    // Response buffer head.
    assign resp_val_i    = ~reset & (count != 2'd0);
    assign bus.resp_val  = resp_val_i;
    assign bus.resp_type = resp_val_i ? buf_type[rd_ptr] : 1'b0;
    assign bus.resp_data = resp_val_i ? buf_data[rd_ptr] : '0;
    assign deq           = resp_val_i & bus.resp_rdy;

    // Credit rule: the pending request plus buffered entries, less the one
    // leaving this cycle, must leave room for the next accept.
    assign occ       = {1'b0, count} + {2'b00, p_val};
    assign req_rdy_i = ~reset & ((occ - {2'b00, deq}) < 3'd2);
    assign bus.req_rdy = req_rdy_i;

    // Read data is only meaningful for a pending read; writes return zero.
    assign push      = p_val;
    assign push_data = p_type ? '0 : sram_read_data;
    assign wr_ptr    = rd_ptr ^ count[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            p_val    <= 1'b0;
            p_type   <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            buf_type <= '0;
            buf_data <= '0;
        end else begin
            p_val <= fire;
            if (fire) begin
                p_type <= bus.req_type;
            end
            if (push) begin
                buf_type[wr_ptr] <= p_type;
                buf_data[wr_ptr] <= push_data;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    a_req_val_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(bus.req_val));
    a_fire_known: assert property (@(posedge clk) disable iff (reset)
        fire |-> !$isunknown({bus.req_type, bus.req_addr}));
    a_addr_range: assert property (@(posedge clk) disable iff (reset)
        fire |-> (int'(bus.req_addr) < p_num_entries));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> (count != 2'd2));

endmodule

// File: tb/tb_sram_1rw_req_resp_adapter.sv
module tb_sram_1rw_req_resp_adapter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sram_read_en;
    logic [7:0]  sram_read_addr;
    logic [31:0] sram_read_data = '0;
    logic        sram_write_en;
    logic [3:0]  sram_write_byte_en;
    logic [7:0]  sram_write_addr;
    logic [31:0] sram_write_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_1rw_req_resp_adapter_if #(.p_data_nbits(32), .p_num_entries(256)) bus ();

    sram_1rw_req_resp_adapter #(.p_data_nbits(32), .p_num_entries(256)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .sram_read_en       (sram_read_en),
        .sram_read_addr     (sram_read_addr),
        .sram_read_data     (sram_read_data),
        .sram_write_en      (sram_write_en),
        .sram_write_byte_en (sram_write_byte_en),
        .sram_write_addr    (sram_write_addr),
        .sram_write_data    (sram_write_data)
    );

    // SRAM: write commits at the edge, read data appears after the edge;
    // outside a read the data bus carries junk.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (sram_write_en)
            for (int b = 0; b < 4; b++)
                if (sram_write_byte_en[b])
                    mem[sram_write_addr][b*8 +: 8] <= sram_write_data[b*8 +: 8];
        if (sram_read_en) sram_read_data <= mem[sram_read_addr];
        else              sram_read_data <= $urandom();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outstanding responses in order, with accept edge.
    typedef struct { logic typ; logic [31:0] data; int stamp; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [256];
    int          edges = 0;
    int          pops = 0;
    logic        s_reset = 1'b1, s_fire = 1'b0, s_deq = 1'b0, s_dut_deq = 1'b0;
    logic        s_type = 1'b0;
    logic [7:0]  s_addr = '0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_strb = '0;

    always @(negedge clk) begin
        logic exp_rval, exp_rdy, exp_fire, exp_deq;
        exp_fire = 1'b0;
        exp_deq  = 1'b0;
        if (reset) begin
            chk("rst_resp_val", {31'b0, bus.resp_val}, 32'd0);
            chk("rst_ctl", {28'b0, bus.resp_type, bus.req_rdy, sram_read_en, sram_write_en}, 32'd0);
            chk("rst_resp_data", bus.resp_data, 32'd0);
        end else begin
            exp_rval = (exp_q.size() != 0) && (edges >= exp_q[0].stamp + 1);
            chk("resp_val", {31'b0, bus.resp_val}, {31'b0, exp_rval});
            if (exp_rval && bus.resp_val) begin
                chk("resp_type", {31'b0, bus.resp_type}, {31'b0, exp_q[0].typ});
                chk("resp_data", bus.resp_data, exp_q[0].data);
            end
            exp_deq  = exp_rval & bus.resp_rdy;
            exp_rdy  = (exp_q.size() - int'(exp_deq)) < 2;
            exp_fire = bus.req_val & exp_rdy;
            chk("req_rdy", {31'b0, bus.req_rdy}, {31'b0, exp_rdy});
            chk("read_en", {31'b0, sram_read_en}, {31'b0, exp_fire & ~bus.req_type});
            chk("write_en", {31'b0, sram_write_en}, {31'b0, exp_fire & bus.req_type});
            chk("rw_excl", {31'b0, sram_read_en & sram_write_en}, 32'd0);
            chk("sram_addr", {16'b0, sram_read_addr, sram_write_addr}, {16'b0, bus.req_addr, bus.req_addr});
            chk("sram_wdata", sram_write_data, bus.req_data);
            chk("sram_strb", {28'b0, sram_write_byte_en}, {28'b0, bus.req_strb});
        end
        s_reset   = reset;
        s_fire    = exp_fire;
        s_deq     = exp_deq;
        s_dut_deq = bus.resp_val & bus.resp_rdy;
        s_type    = bus.req_type;
        s_addr    = bus.req_addr;
        s_data    = bus.req_data;
        s_strb    = bus.req_strb;
    end

    always @(posedge clk) begin
        edges++;
        if (s_dut_deq) pops++;
        if (s_reset) begin
            exp_q.delete();
        end else begin
            if (s_deq) void'(exp_q.pop_front());
            if (s_fire) begin
                if (s_type) begin
                    for (int b = 0; b < 4; b++)
                        if (s_strb[b]) ref_mem[s_addr][b*8 +: 8] = s_data[b*8 +: 8];
                    exp_q.push_back('{typ: 1'b1, data: 32'd0, stamp: edges});
                end else begin
                    exp_q.push_back('{typ: 1'b0, data: ref_mem[s_addr], stamp: edges});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic t, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic rr);
        @(posedge clk);
        #1;
        bus.req_val  = v;
        bus.req_type = t;
        bus.req_addr = a;
        bus.req_data = d;
        bus.req_strb = s;
        bus.resp_rdy = rr;
    endtask

    typedef struct {
        logic v; logic t; logic [7:0] a; logic [31:0] d; logic [3:0] s; logic rr;
        logic e_rdy; logic e_rval; logic e_rtype; logic [31:0] e_rdata; logic e_ren; logic e_wen;
    } vec_t;
    vec_t vecs[$];

    initial begin
        int p0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.req_val = 0; bus.req_type = 0; bus.req_addr = '0;
        bus.req_data = '0; bus.req_strb = '0; bus.resp_rdy = 1'b1;

        // write then read; partial write; backpressure
        vecs.push_back(vec_t'{1,1,8'd5,32'hDEADBEEF,4'hF,1, 1,0,0,32'h0,0,1});
        vecs.push_back(vec_t'{1,0,8'd5,32'h0,4'h0,1,        1,0,0,32'h0,1,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,1,1,32'h0,0,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,1,0,32'hDEADBEEF,0,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,0,0,32'h0,0,0});
        vecs.push_back(vec_t'{1,1,8'd9,32'h11223344,4'hF,1, 1,0,0,32'h0,0,1});
        vecs.push_back(vec_t'{1,1,8'd9,32'hAABBCCDD,4'h5,1, 1,0,0,32'h0,0,1});
        vecs.push_back(vec_t'{1,0,8'd9,32'h0,4'h0,1,        1,1,1,32'h0,1,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,1,1,32'h0,0,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,1,0,32'h11BB33DD,0,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,0,0,32'h0,0,0});
        vecs.push_back(vec_t'{1,0,8'd5,32'h0,4'h0,0,        1,0,0,32'h0,1,0});
        vecs.push_back(vec_t'{1,0,8'd9,32'h0,4'h0,0,        1,0,0,32'h0,1,0});
        vecs.push_back(vec_t'{1,0,8'd0,32'h0,4'h0,0,        0,1,0,32'hDEADBEEF,0,0});
        vecs.push_back(vec_t'{1,0,8'd0,32'h0,4'h0,0,        0,1,0,32'hDEADBEEF,0,0});
        vecs.push_back(vec_t'{1,0,8'd0,32'h0,4'h0,1,        1,1,0,32'hDEADBEEF,1,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,1,0,32'h11BB33DD,0,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,1,0,32'h0,0,0});
        vecs.push_back(vec_t'{0,0,8'd0,32'h0,4'h0,1,        1,0,0,32'h0,0,0});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].rr);
            @(negedge clk);
            chk($sformatf("vec%0d_req_rdy", i), {31'b0, bus.req_rdy}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_resp_val", i), {31'b0, bus.resp_val}, {31'b0, vecs[i].e_rval});
            chk($sformatf("vec%0d_resp_type", i), {31'b0, bus.resp_type}, {31'b0, vecs[i].e_rtype});
            chk($sformatf("vec%0d_resp_data", i), bus.resp_data, vecs[i].e_rdata);
            chk($sformatf("vec%0d_ren_wen", i), {30'b0, sram_read_en, sram_write_en},
                {30'b0, vecs[i].e_ren, vecs[i].e_wen});
        end

        // streaming: 8 writes then 8 reads, full throughput
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i < 8, 8'(i % 8), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, 1'b1);
            @(negedge clk);
            chk("stream_req_rdy", {31'b0, bus.req_rdy}, 32'd1);
        end
        repeat (4) drive(1'b0, 1'b0, 8'd0, 32'd0, 4'h0, 1'b1);
        @(negedge clk);
        chk("stream_pops", 32'(pops - p0), 32'd16);

        // reset one cycle after a read is accepted
        drive(1'b1, 1'b1, 8'd20, 32'hCAFEF00D, 4'hF, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 8'd0, 32'd0, 4'h0, 1'b1);
        drive(1'b1, 1'b0, 8'd20, 32'd0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_val = 1'b0;
        @(negedge clk);
        chk("midrst_resp_val", {31'b0, bus.resp_val}, 32'd0);
        chk("midrst_req_rdy", {31'b0, bus.req_rdy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'b0, bus.resp_val}, 32'd0);
        end
        drive(1'b1, 1'b0, 8'd20, 32'd0, 4'h0, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 4'h0, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 4'h0, 1'b1);
        @(negedge clk);
        chk("post_rst_read_val", {31'b0, bus.resp_val}, 32'd1);
        chk("post_rst_read_data", bus.resp_data, 32'hCAFEF00D);

        // random mixed traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 7);
        end
        drive(1'b0, 1'b0, 8'd0, 32'd0, 4'h0, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
